// File: rtl/time_set_ctrl.sv
// Mode/edit sequencer for the HH:MM:SS chain: show/set states, field select, auto-repeat INC,
// set-mode inactivity timeout and divider re-align on exit. Optional blink: TIME_SET_BLINK_EN.
module time_set_ctrl #(
    parameter int REPEAT_DLY_CYC = 25_000_000,
    parameter int REPEAT_PER_CYC = 5_000_000,
    parameter int TIMEOUT_CYC    = 500_000_000,
    parameter int BLINK_HALF_CYC = 12_500_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_btn_mode,
    input  logic       i_btn_inc,
    input  logic       i_btn_inc_held,
    output logic       o_tick_en,
    output logic       o_div_clr,
    output logic       o_inc_sec,
    output logic       o_inc_min,
    output logic       o_inc_hour,
    output logic [1:0] o_disp_sel,
    output logic       o_setting,
    output logic       o_blank
);

    typedef enum logic [2:0] {
        SHW_SEC, SHW_MIN, SHW_HOUR, SET_SEC, SET_MIN, SET_HOUR
    } state_t;

    localparam int RPT_MAX = (REPEAT_DLY_CYC > REPEAT_PER_CYC) ? REPEAT_DLY_CYC : REPEAT_PER_CYC;
    localparam int RW = $clog2(RPT_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [RW-1:0] RPT_DLY = RW'(REPEAT_DLY_CYC);
    localparam logic [RW-1:0] RPT_PER = RW'(REPEAT_PER_CYC);
    localparam logic [TW-1:0] TMO     = TW'(TIMEOUT_CYC);

    state_t        state, state_nxt;
    logic          in_set;
    logic [RW-1:0] rpt_cnt, rpt_cnt_nxt;
    logic          rpt_armed, rpt_armed_nxt;
    logic          rpt_fire;
    logic [TW-1:0] idle_cnt, idle_cnt_nxt;
    logic          timeout;
    logic          exit_set;
    logic          inc_fire;
    logic [1:0]    field;

    assign in_set    = (state == SET_SEC) || (state == SET_MIN) || (state == SET_HOUR);
    assign o_tick_en = ~in_set;

    always_comb begin
        state_nxt     = state;
        rpt_cnt_nxt   = '0;
        rpt_armed_nxt = 1'b0;
        rpt_fire      = 1'b0;
        idle_cnt_nxt  = '0;
        timeout       = 1'b0;
        exit_set      = 1'b0;
        inc_fire      = 1'b0;
        field         = 2'd0;

        if (in_set) begin
            if (!(i_btn_mode || i_btn_inc || i_btn_inc_held)) begin
                if (idle_cnt + 1'b1 == TMO) timeout = 1'b1;
                else                        idle_cnt_nxt = idle_cnt + 1'b1;
            end
            // Two-phase repeat: initial delay, then fixed period once armed.
            if (i_btn_inc_held) begin
                rpt_armed_nxt = rpt_armed;
                if (rpt_cnt + 1'b1 == (rpt_armed ? RPT_PER : RPT_DLY)) begin
                    rpt_fire      = 1'b1;
                    rpt_armed_nxt = 1'b1;
                end else begin
                    rpt_cnt_nxt = rpt_cnt + 1'b1;
                end
            end
        end

        case (state)
            SHW_SEC:  if (i_btn_mode) state_nxt = SET_SEC; else if (i_btn_inc) state_nxt = SHW_MIN;
            SHW_MIN:  if (i_btn_mode) state_nxt = SET_SEC; else if (i_btn_inc) state_nxt = SHW_HOUR;
            SHW_HOUR: if (i_btn_mode) state_nxt = SET_SEC; else if (i_btn_inc) state_nxt = SHW_SEC;
            SET_SEC:  if (i_btn_mode) state_nxt = SET_MIN;
            SET_MIN:  if (i_btn_mode) state_nxt = SET_HOUR;
            SET_HOUR: if (i_btn_mode) begin
                          state_nxt = SHW_SEC;
                          exit_set  = 1'b1;
                      end
            default:  state_nxt = SHW_SEC;
        endcase

        if (in_set && !i_btn_mode && timeout) begin
            state_nxt = SHW_SEC;
            exit_set  = 1'b1;
        end

        // Any state change restarts auto-repeat and suppresses the increment.
        if (in_set && (i_btn_mode || timeout)) begin
            rpt_cnt_nxt   = '0;
            rpt_armed_nxt = 1'b0;
        end else if (in_set) begin
            inc_fire = i_btn_inc || rpt_fire;
        end

        case (state)
            SHW_MIN, SET_MIN:   field = 2'd1;
            SHW_HOUR, SET_HOUR: field = 2'd2;
            default:            field = 2'd0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= SHW_SEC;
            rpt_cnt    <= '0;
            rpt_armed  <= 1'b0;
            idle_cnt   <= '0;
            o_div_clr  <= 1'b0;
            o_inc_sec  <= 1'b0;
            o_inc_min  <= 1'b0;
            o_inc_hour <= 1'b0;
            o_disp_sel <= 2'd0;
            o_setting  <= 1'b0;
        end else begin
            state      <= state_nxt;
            rpt_cnt    <= rpt_cnt_nxt;
            rpt_armed  <= rpt_armed_nxt;
            idle_cnt   <= idle_cnt_nxt;
            o_div_clr  <= exit_set;
            o_inc_sec  <= inc_fire && (state == SET_SEC);
            o_inc_min  <= inc_fire && (state == SET_MIN);
            o_inc_hour <= inc_fire && (state == SET_HOUR);
            o_disp_sel <= field;
            o_setting  <= in_set;
        end
    end

`ifdef TIME_SET_BLINK_EN
    localparam int BW = $clog2(BLINK_HALF_CYC + 1);
    localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_HALF_CYC);

    logic [BW-1:0] blink_cnt;
    logic          state_chg;

    assign state_chg = (state_nxt != state);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink_cnt <= '0;
            o_blank   <= 1'b0;
        end else if (!in_set || state_chg || inc_fire) begin
            blink_cnt <= '0;
            o_blank   <= 1'b0;
        end else if (blink_cnt + 1'b1 == BLINK_HALF) begin
            blink_cnt <= '0;
            o_blank   <= ~o_blank;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`else
    // Blink disabled: the comparison is constant 0 for any legal half-period.
    assign o_blank = (BLINK_HALF_CYC < 0);
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus random button traffic, every cycle
// compared against a behavioural model of the show/set sequencer.
module tb_time_set_ctrl;

    localparam int DLY  = 20;
    localparam int PER  = 5;
    localparam int TMO  = 100;
    localparam int HALF = 8;

    // Inputs are applied #1 after a rising edge and sampled at the next one.
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_held = 1'b0;
    logic       tick_en, div_clr, inc_sec, inc_min, inc_hour, setting, blank;
    logic [1:0] disp_sel;

    time_set_ctrl #(
        .REPEAT_DLY_CYC(DLY), .REPEAT_PER_CYC(PER),
        .TIMEOUT_CYC(TMO), .BLINK_HALF_CYC(HALF)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_btn_mode(btn_mode), .i_btn_inc(btn_inc), .i_btn_inc_held(btn_held),
        .o_tick_en(tick_en), .o_div_clr(div_clr),
        .o_inc_sec(inc_sec), .o_inc_min(inc_min), .o_inc_hour(inc_hour),
        .o_disp_sel(disp_sel), .o_setting(setting), .o_blank(blank)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: mode (show/set), field index, elapsed-cycle counts.
    bit       m_set;
    int       m_field, m_hold, m_idle, m_blink;
    bit       e_tick, e_div, e_setting, e_blank;
    bit [2:0] e_inc;
    int       e_sel;
    int       n_sec, n_min, n_hour, n_div;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_set = 0; m_field = 0; m_hold = 0; m_idle = 0; m_blink = 0;
        e_tick = 1; e_div = 0; e_setting = 0; e_blank = 0; e_inc = 3'b000; e_sel = 0;
    endtask

    task automatic model_step(input bit mode, input bit inc, input bit held);
        bit old_set, changed, timed, rpt;
        old_set = m_set;
        e_sel = m_field; e_setting = old_set; e_div = 0; e_inc = 3'b000;
        changed = 0; timed = 0; rpt = 0;
        if (old_set) begin
            if (mode || inc || held) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle == TMO) begin timed = 1; m_idle = 0; end
            end
            if (held && !mode && !timed) m_hold++; else m_hold = 0;
            rpt = (m_hold >= DLY) && ((m_hold - DLY) % PER == 0);
            if (mode) begin
                changed = 1;
                if (m_field == 2) begin m_set = 0; m_field = 0; e_div = 1; end
                else m_field++;
            end else if (timed) begin
                changed = 1; m_set = 0; m_field = 0; e_div = 1;
            end else if (inc || rpt) begin
                e_inc[m_field] = 1'b1;
            end
        end else begin
            m_hold = 0; m_idle = 0;
            if (mode) begin m_set = 1; m_field = 0; end
            else if (inc) m_field = (m_field + 1) % 3;
        end
        e_tick = !m_set;
`ifdef TIME_SET_BLINK_EN
        if (!old_set || changed || (e_inc != 3'b000)) m_blink = 0;
        else m_blink++;
        e_blank = ((m_blink / HALF) % 2) == 1;
`else
        e_blank = 0;
`endif
    endtask

    task automatic check_all(input string tag);
        check({tag, ".tick_en"},  tick_en,  e_tick);
        check({tag, ".div_clr"},  div_clr,  e_div);
        check({tag, ".inc_sec"},  inc_sec,  e_inc[0]);
        check({tag, ".inc_min"},  inc_min,  e_inc[1]);
        check({tag, ".inc_hour"}, inc_hour, e_inc[2]);
        check({tag, ".disp_sel"}, disp_sel, e_sel);
        check({tag, ".setting"},  setting,  e_setting);
        check({tag, ".blank"},    blank,    e_blank);
    endtask

    task automatic cyc(input string tag, input bit mode, input bit inc, input bit held);
        btn_mode = mode; btn_inc = inc; btn_held = held;
        @(posedge clk);
        if (rst_n) model_step(mode, inc, held);
        else       model_reset();
        #1;
        check_all(tag);
        if (inc_sec)  n_sec++;
        if (inc_min)  n_min++;
        if (inc_hour) n_hour++;
        if (div_clr)  n_div++;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0);
    endtask

    task automatic clr_tally();
        n_sec = 0; n_min = 0; n_hour = 0; n_div = 0;
    endtask

    initial begin
        bit r_mode, r_inc, r_held;
        model_reset();
        clr_tally();

        // Reset values
        #1;
        check_all("reset");
        cyc("reset", 0, 0, 0);
        cyc("reset", 0, 0, 0);
        rst_n = 1'b1;
        idle("post_reset", 2);

        // Show-field cycling: sel 1, 2, 0
        for (int i = 0; i < 3; i++) begin
            cyc("shw_inc", 0, 1, 0);
            idle("shw_inc", 1);
        end
        check("shw_wrap_sel", disp_sel, 0);

        // Edit sequence: 3 sec, 2 min, 1 hour increments then exit
        clr_tally();
        cyc("edit", 1, 0, 0);
        for (int i = 0; i < 3; i++) begin cyc("edit_sec", 0, 1, 0); idle("edit_sec", 1); end
        cyc("edit", 1, 0, 0);
        for (int i = 0; i < 2; i++) begin cyc("edit_min", 0, 1, 0); idle("edit_min", 1); end
        cyc("edit", 1, 0, 0);
        cyc("edit_hour", 0, 1, 0);
        idle("edit_hour", 1);
        cyc("edit_exit", 1, 0, 0);
        idle("edit_exit", 2);
        check("edit_n_sec", n_sec, 3);
        check("edit_n_min", n_min, 2);
        check("edit_n_hour", n_hour, 1);
        check("edit_n_div", n_div, 1);
        check("edit_tick_en", tick_en, 1);

        // Auto-repeat in SET_MIN: 40 held cycles give 5 pulses
        cyc("rpt", 1, 0, 0);
        cyc("rpt", 1, 0, 0);
        clr_tally();
        for (int i = 0; i < 40; i++) cyc("rpt_hold", 0, 0, 1);
        idle("rpt_rel", 3);
        check("rpt_n_min", n_min, 5);

        // Timeout from SET_HOUR, then idle in SHW has no effect
        cyc("tmo", 1, 0, 0);
        clr_tally();
        idle("tmo_set", 101);
        check("tmo_n_div", n_div, 1);
        check("tmo_setting", setting, 0);
        clr_tally();
        idle("tmo_shw", 120);
        check("shw_idle_n_div", n_div, 0);
        check("shw_idle_sel", disp_sel, 0);

        // Mode and inc together in SET_SEC: mode wins
        cyc("simul", 1, 0, 0);
        idle("simul", 2);
        clr_tally();
        cyc("simul", 1, 1, 0);
        idle("simul", 2);
        check("simul_n_inc", n_sec + n_min, 0);
        check("simul_sel", disp_sel, 1);

        // Blink phase in SET_SEC with an inc restart (flat 0 without the feature)
        cyc("blink", 1, 0, 0);
        cyc("blink", 1, 0, 0);
        cyc("blink", 1, 0, 0);
        idle("blink", 20);
        cyc("blink_inc", 0, 1, 0);
        idle("blink", 20);

        // Reset in the middle of an auto-repeat run
        cyc("rst_rpt", 1, 0, 0);
        for (int i = 0; i < 27; i++) cyc("rst_rpt_hold", 0, 0, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        cyc("rst_low", 0, 0, 1);
        cyc("rst_low", 0, 0, 1);
        rst_n = 1'b1;
        clr_tally();
        for (int i = 0; i < 30; i++) cyc("rst_rel_hold", 0, 0, 1);
        check("rst_rel_n_inc", n_sec + n_min + n_hour, 0);

        // Random button traffic
        r_held = 0;
        for (int i = 0; i < 3000; i++) begin
            r_mode = ($urandom_range(0, 99) < 3);
            r_inc  = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 99) < 4) r_held = ~r_held;
            cyc("rand", r_mode, r_inc, r_held);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
